mem_burst_model: RTL

Parametrised line-burst backing-memory model for the cache testbench, successor to the fixed-geometry `mem`. It sits on the cache's memory-side shared bus and serves whole cache-line READ and WRITE requests. Each request is answered after a programmable latency, with the line transferred as a burst of `BUS_SIZE`-bit words. Geometry, bus width and response latency are all parameters; the older model hard-codes them.

---
 rtl/mem_burst_model.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_burst_model.sv
// rtl/mem_burst_model.sv - line-burst backing memory with programmable response latency
module mem_burst_model #(
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int BUS_SIZE          = 16,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int CACHE_LINE_SIZE   = 16,
    parameter int RESP_LATENCY      = 100
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] mem_address,
    inout  wire  [BUS_SIZE-1:0]                    mem_data,
    inout  wire  [1:0]                             mem_command
);
    localparam int WORDS  = CACHE_LINE_SIZE * 8 / BUS_SIZE;
    localparam int BYTES  = BUS_SIZE / 8;
    localparam int LINE_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int K_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int WIDX_W = MEM_ADDR_SIZE - $clog2(BYTES);
    localparam int DEPTH  = 2 ** WIDX_W;
    localparam int CNT_W  = $clog2(RESP_LATENCY + 1);

    localparam logic [1:0] CMD_RESP  = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_WRITE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_DATA,
        S_WAIT,
        S_RD_DATA,
        S_WR_ACK
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [LINE_W-1:0]    line_q, line_d;
    logic                 is_wr_q, is_wr_d;
    logic                 we;
    logic                 drive_cmd;
    logic                 drive_data;
    logic [WIDX_W-1:0]    wr_idx;
    logic [WIDX_W-1:0]    rd_idx;
    logic [BUS_SIZE-1:0]  rd_word;

    // Storage holds the XOR against the power-up pattern, so an all-zero
    // array reads back as byte(a) = a[7:0] ^ a[15:8] without any init pass.
    logic [BUS_SIZE-1:0]  delta [DEPTH];

    function automatic logic [BUS_SIZE-1:0] init_word(input logic [WIDX_W-1:0] w);
        logic [15:0] a;
        init_word = '0;
        for (int b = 0; b < BYTES; b++) begin
            a = 16'(32'(w) * 32'(BYTES) + 32'(b));
            init_word[b*8 +: 8] = a[7:0] ^ a[15:8];
        end
    endfunction

    function automatic logic [WIDX_W-1:0] word_index(input logic [LINE_W-1:0] line,
                                                     input logic [K_W-1:0]    k);
        word_index = WIDX_W'(line) * WIDX_W'(WORDS) + WIDX_W'(k);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            line_q  <= '0;
            is_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            line_q  <= line_d;
            is_wr_q <= is_wr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        line_d     = line_q;
        is_wr_d    = is_wr_q;
        we         = 1'b0;
        drive_cmd  = 1'b0;
        drive_data = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_command == CMD_READ) begin
                    line_d  = mem_address;
                    is_wr_d = 1'b0;
                    cnt_d   = CNT_W'(RESP_LATENCY);
                    state_d = S_WAIT;
                end else if (mem_command == CMD_WRITE) begin
                    line_d  = mem_address;
                    is_wr_d = 1'b1;
                    we      = 1'b1;
                    if (WORDS == 1) begin
                        cnt_d   = CNT_W'(RESP_LATENCY);
                        state_d = S_WAIT;
                    end else begin
                        k_d     = K_W'(1);
                        state_d = S_WR_DATA;
                    end
                end
            end
            S_WR_DATA: begin
                we = 1'b1;
                if (k_q == K_W'(WORDS - 1)) begin
                    k_d     = '0;
                    cnt_d   = CNT_W'(RESP_LATENCY);
                    state_d = S_WAIT;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    k_d     = '0;
                    state_d = is_wr_q ? S_WR_ACK : S_RD_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RD_DATA: begin
                drive_cmd  = 1'b1;
                drive_data = 1'b1;
                if (k_q == K_W'(WORDS - 1)) begin
                    k_d     = '0;
                    state_d = S_IDLE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_WR_ACK: begin
                drive_cmd = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Word 0 of a write arrives with the command, before line_q is loaded.
    assign wr_idx = (state_q == S_IDLE) ? word_index(mem_address, '0)
                                        : word_index(line_q, k_q);
    assign rd_idx = word_index(line_q, k_q);

    always_ff @(posedge clk) begin
        if (we && !reset) begin
            delta[wr_idx] <= mem_data ^ init_word(wr_idx);
        end
    end

    assign rd_word     = delta[rd_idx] ^ init_word(rd_idx);
    assign mem_command = drive_cmd  ? CMD_RESP : 2'bzz;
    assign mem_data    = drive_data ? rd_word  : {BUS_SIZE{1'bz}};

endmodule
